bp_btb2w: RTL and testbench

BP_BTB2W -- requirements
Module: bp_btb2w

---
 rtl/bp_btb2w_if.sv | 29 ++
 rtl/bp_btb2w.sv | 148 ++++++++++++++
 tb/tb_bp_btb2w.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bp_btb2w_if.sv
// Fetch-lookup and EX-resolve signal bundle for the 2-way branch target buffer.
interface bp_btb2w_if;
    logic [31:0] pc_if;
    logic        hit;
    logic        pred_taken;
    logic [31:0] npc_pred;
    logic        ex_valid;
    logic        is_br_ex;
    logic        br_ex;
    logic [31:0] pc_ex;
    logic [31:0] br_target;
    logic        pred_taken_ex;
    logic [31:0] pred_target_ex;
    logic        fail;
    logic [31:0] br_total;
    logic [31:0] br_fail;

    modport master (
        output pc_if, ex_valid, is_br_ex, br_ex, pc_ex, br_target,
               pred_taken_ex, pred_target_ex,
        input  hit, pred_taken, npc_pred, fail, br_total, br_fail
    );

    modport slave (
        input  pc_if, ex_valid, is_br_ex, br_ex, pc_ex, br_target,
               pred_taken_ex, pred_target_ex,
        output hit, pred_taken, npc_pred, fail, br_total, br_fail
    );
endinterface

// File: rtl/bp_btb2w.sv
// 2-way set-associative BTB with 2-bit counters and per-set LRU victim bit.
// Lookup and fail are combinational; updates land on the next edge, no backpressure.
module bp_btb2w #(
    parameter int SET_ADDR_LEN = 6
) (
    input logic        clk,
    input logic        rst_n,
    bp_btb2w_if.slave  btb
);
    localparam int TAG_LEN = 30 - SET_ADDR_LEN;
    localparam int SETS    = 1 << SET_ADDR_LEN;

    typedef logic [SET_ADDR_LEN-1:0] set_t;
    typedef logic [TAG_LEN-1:0]      tag_t;

    logic        valid_q [2][SETS];
    tag_t        tag_q   [2][SETS];
    logic [31:0] tgt_q   [2][SETS];
    logic [1:0]  ctr_q   [2][SETS];
    logic [SETS-1:0] lru_q;
    logic [31:0] br_total_q, br_total_d;
    logic [31:0] br_fail_q, br_fail_d;

    // Fetch-side lookup
    set_t       set_if;
    tag_t       tag_if;
    logic [1:0] if_hit_w;
    logic       if_way;

    assign set_if      = btb.pc_if[SET_ADDR_LEN+1:2];
    assign tag_if      = btb.pc_if[31:SET_ADDR_LEN+2];
    assign if_hit_w[0] = valid_q[0][set_if] && (tag_q[0][set_if] == tag_if);
    assign if_hit_w[1] = valid_q[1][set_if] && (tag_q[1][set_if] == tag_if);
    assign if_way      = if_hit_w[1];

    assign btb.hit        = |if_hit_w;
    assign btb.pred_taken = btb.hit && ctr_q[if_way][set_if][1];
    assign btb.npc_pred   = btb.pred_taken ? tgt_q[if_way][set_if] : btb.pc_if + 32'd4;

    // EX-side lookup against the same pre-update contents
    set_t       set_ex;
    tag_t       tag_ex;
    logic [1:0] ex_hit_w;
    logic       ex_hit;
    logic       ex_way;
    logic       br_tk;
    logic       victim;

    assign set_ex      = btb.pc_ex[SET_ADDR_LEN+1:2];
    assign tag_ex      = btb.pc_ex[31:SET_ADDR_LEN+2];
    assign ex_hit_w[0] = valid_q[0][set_ex] && (tag_q[0][set_ex] == tag_ex);
    assign ex_hit_w[1] = valid_q[1][set_ex] && (tag_q[1][set_ex] == tag_ex);
    assign ex_hit      = |ex_hit_w;
    assign ex_way      = ex_hit_w[1];
    assign br_tk       = btb.is_br_ex && btb.br_ex;
    assign victim      = !valid_q[0][set_ex] ? 1'b0 :
                         !valid_q[1][set_ex] ? 1'b1 : lru_q[set_ex];

    assign btb.fail = btb.ex_valid && (
                         (!btb.is_br_ex && btb.pred_taken_ex) ||
                         (btb.is_br_ex && (btb.pred_taken_ex != btb.br_ex)) ||
                         (br_tk && btb.pred_taken_ex && (btb.pred_target_ex != btb.br_target)));

    // Single-entry write port: at most one way of one set changes per cycle
    logic        upd_en;
    logic        upd_way;
    logic        ent_vld_d;
    tag_t        ent_tag_d;
    logic [31:0] ent_tgt_d;
    logic [1:0]  ent_ctr_d;
    logic [1:0]  ctr_cur;
    logic        lru_upd;
    logic        lru_d;

    assign ctr_cur = ctr_q[ex_way][set_ex];

    always_comb begin
        upd_en    = 1'b0;
        upd_way   = ex_way;
        ent_vld_d = valid_q[ex_way][set_ex];
        ent_tag_d = tag_q[ex_way][set_ex];
        ent_tgt_d = tgt_q[ex_way][set_ex];
        ent_ctr_d = ctr_cur;
        lru_upd   = 1'b0;
        lru_d     = lru_q[set_ex];
        if (btb.ex_valid) begin
            if (ex_hit) begin
                upd_en = 1'b1;
                if (btb.is_br_ex) begin
                    if (btb.br_ex) begin
                        ent_ctr_d = (ctr_cur != 2'b11) ? ctr_cur + 2'd1 : ctr_cur;
                        ent_tgt_d = btb.br_target;
                    end else begin
                        ent_ctr_d = (ctr_cur != 2'b00) ? ctr_cur - 2'd1 : ctr_cur;
                    end
                    lru_upd = 1'b1;
                    lru_d   = ~ex_way;
                end else begin
                    // Non-branch matched an entry: drop the stale alias
                    ent_vld_d = 1'b0;
                end
            end else if (br_tk) begin
                upd_en    = 1'b1;
                upd_way   = victim;
                ent_vld_d = 1'b1;
                ent_tag_d = tag_ex;
                ent_tgt_d = btb.br_target;
                ent_ctr_d = 2'b10;
                lru_upd   = 1'b1;
                lru_d     = ~victim;
            end
        end
    end

    assign br_total_d = br_total_q + ((btb.ex_valid && btb.is_br_ex) ? 32'd1 : 32'd0);
    assign br_fail_d  = br_fail_q + (btb.fail ? 32'd1 : 32'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int w = 0; w < 2; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    tag_q[w][s]   <= '0;
                    tgt_q[w][s]   <= '0;
                    ctr_q[w][s]   <= 2'b01;
                end
            end
            lru_q      <= '0;
            br_total_q <= '0;
            br_fail_q  <= '0;
        end else begin
            if (upd_en) begin
                valid_q[upd_way][set_ex] <= ent_vld_d;
                tag_q[upd_way][set_ex]   <= ent_tag_d;
                tgt_q[upd_way][set_ex]   <= ent_tgt_d;
                ctr_q[upd_way][set_ex]   <= ent_ctr_d;
            end
            if (lru_upd) begin
                lru_q[set_ex] <= lru_d;
            end
            br_total_q <= br_total_d;
            br_fail_q  <= br_fail_d;
        end
    end

    assign btb.br_total = br_total_q;
    assign btb.br_fail  = br_fail_q;
endmodule

// File: tb/tb_bp_btb2w.sv
// Bench for bp_btb2w: directed scenarios plus random traffic against a table-level model.
module tb_bp_btb2w;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bp_btb2w_if bus ();
    bp_btb2w #(.SET_ADDR_LEN(6)) dut (.clk(clk), .rst_n(rst_n), .btb(bus));

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: 64 sets x 2 ways, entries addressed by plain PC arithmetic
    bit          mv   [64][2];
    bit [31:0]   mtag [64][2];
    bit [31:0]   mtgt [64][2];
    int          mctr [64][2];
    bit          mlru [64];
    bit [31:0]   mtot, mfl;
    bit          last_fail;

    function automatic int mset(input bit [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int mway(input bit [31:0] pc);
        int s;
        s = mset(pc);
        for (int w = 0; w < 2; w++)
            if (mv[s][w] && mtag[s][w] == pc / 256) return w;
        return -1;
    endfunction

    function automatic bit mpt(input bit [31:0] pc);
        int w;
        w = mway(pc);
        return (w >= 0) && (mctr[mset(pc)][w] >= 2);
    endfunction

    function automatic bit [31:0] mnpc(input bit [31:0] pc);
        if (mpt(pc)) return mtgt[mset(pc)][mway(pc)];
        return pc + 32'd4;
    endfunction

    task automatic mreset();
        for (int s = 0; s < 64; s++) begin
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 0; mtag[s][w] = 0; mtgt[s][w] = 0; mctr[s][w] = 1;
            end
            mlru[s] = 0;
        end
        mtot = 0; mfl = 0;
    endtask

    task automatic cyc(input bit rst, input bit [31:0] pcif, input bit exv, input bit isbr,
                       input bit br, input bit [31:0] pcex, input bit [31:0] tgt,
                       input bit pte, input bit [31:0] ptg);
        bit ef;
        int w, s, v;
        rst_n = !rst;
        bus.pc_if = pcif; bus.ex_valid = exv; bus.is_br_ex = isbr; bus.br_ex = br;
        bus.pc_ex = pcex; bus.br_target = tgt; bus.pred_taken_ex = pte; bus.pred_target_ex = ptg;
        #2;
        ef = exv && ((!isbr && pte) || (isbr && (pte != br)) || (isbr && br && pte && ptg != tgt));
        chk("hit", {31'd0, bus.hit}, {31'd0, mway(pcif) >= 0});
        chk("pred_taken", {31'd0, bus.pred_taken}, {31'd0, mpt(pcif)});
        chk("npc_pred", bus.npc_pred, mnpc(pcif));
        chk("fail", {31'd0, bus.fail}, {31'd0, ef});
        chk("br_total", bus.br_total, mtot);
        chk("br_fail", bus.br_fail, mfl);
        last_fail = bus.fail;
        if (rst) begin
            mreset();
        end else if (exv) begin
            if (isbr) mtot++;
            if (ef) mfl++;
            w = mway(pcex);
            s = mset(pcex);
            if (w >= 0) begin
                if (isbr) begin
                    if (br) begin
                        mctr[s][w] = (mctr[s][w] < 3) ? mctr[s][w] + 1 : 3;
                        mtgt[s][w] = tgt;
                    end else begin
                        mctr[s][w] = (mctr[s][w] > 0) ? mctr[s][w] - 1 : 0;
                    end
                    mlru[s] = (w == 0);
                end else begin
                    mv[s][w] = 0;
                end
            end else if (isbr && br) begin
                v = !mv[s][0] ? 0 : !mv[s][1] ? 1 : int'(mlru[s]);
                mv[s][v] = 1; mtag[s][v] = pcex / 256; mtgt[s][v] = tgt; mctr[s][v] = 2;
                mlru[s] = (v == 0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tg, input bit [31:0] pc, input bit eh, input bit ept,
                        input bit [31:0] enpc);
        rst_n = 1; bus.pc_if = pc; bus.ex_valid = 0;
        #2;
        chk({tg, "_hit"}, {31'd0, bus.hit}, {31'd0, eh});
        chk({tg, "_pt"}, {31'd0, bus.pred_taken}, {31'd0, ept});
        chk({tg, "_npc"}, bus.npc_pred, enpc);
        cyc(0, pc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ex_br(input bit [31:0] pc, input bit tk, input bit [31:0] tgt,
                         input bit pte, input bit [31:0] ptg);
        cyc(0, 32'h40, 1, 1, tk, pc, tgt, pte, ptg);
    endtask

    initial begin
        bit [31:0] pa, pb, tg;
        bit pte;
        rst_n = 0;
        bus.pc_if = 0; bus.ex_valid = 0; bus.is_br_ex = 0; bus.br_ex = 0;
        bus.pc_ex = 0; bus.br_target = 0; bus.pred_taken_ex = 0; bus.pred_target_ex = 0;
        repeat (2) @(posedge clk);
        #1;
        mreset();

        // Reset state and first allocation
        look("rst", 32'h100, 0, 0, 32'h104);
        chk("rst_total", bus.br_total, 0);
        ex_br(32'h100, 1, 32'h200, 0, 0);
        chk("alloc_fail", {31'd0, last_fail}, 1);
        look("alloc", 32'h100, 1, 1, 32'h200);
        chk("alloc_total", bus.br_total, 1);
        chk("alloc_bfail", bus.br_fail, 1);

        // Counter hysteresis
        ex_br(32'h100, 0, 32'h200, 1, 32'h200);
        look("hys_nt", 32'h100, 1, 0, 32'h104);
        ex_br(32'h100, 1, 32'h200, 0, 0);
        look("hys_t", 32'h100, 1, 1, 32'h200);
        repeat (3) ex_br(32'h100, 1, 32'h200, 1, 32'h200);
        ex_br(32'h100, 0, 32'h200, 1, 32'h200);
        look("hys_sat", 32'h100, 1, 1, 32'h200);

        // Alias purge by a non-branch
        cyc(0, 32'h40, 1, 0, 1, 32'h100, 32'h0, 1, 32'h200);
        chk("alias_fail", {31'd0, last_fail}, 1);
        look("alias", 32'h100, 0, 0, 32'h104);

        // Conflict and LRU replacement in set 0
        do_reset();
        ex_br(32'h100, 1, 32'h200, 0, 0);
        ex_br(32'h1100, 1, 32'h1200, 0, 0);
        ex_br(32'h100, 1, 32'h200, 1, 32'h200);
        ex_br(32'h2100, 1, 32'h2200, 0, 0);
        look("lru_ev", 32'h1100, 0, 0, 32'h1104);
        look("lru_a", 32'h100, 1, 1, 32'h200);
        look("lru_c", 32'h2100, 1, 1, 32'h2200);

        // Target change, then the same resolution gated off
        do_reset();
        ex_br(32'h100, 1, 32'h200, 0, 0);
        ex_br(32'h100, 1, 32'h300, 1, 32'h200);
        chk("tgt_fail", {31'd0, last_fail}, 1);
        look("tgt", 32'h100, 1, 1, 32'h300);
        cyc(0, 32'h40, 0, 1, 1, 32'h100, 32'h500, 1, 32'h300);
        chk("gate_fail", {31'd0, last_fail}, 0);
        look("gate", 32'h100, 1, 1, 32'h300);
        chk("gate_total", bus.br_total, 2);

        // Reset during an allocating EX cycle
        cyc(1, 32'h40, 1, 1, 1, 32'h500, 32'h600, 0, 0);
        look("mrst_a", 32'h100, 0, 0, 32'h104);
        look("mrst_b", 32'h500, 0, 0, 32'h504);
        chk("mrst_total", bus.br_total, 0);
        chk("mrst_bfail", bus.br_fail, 0);

        // Random traffic over a small PC pool so sets conflict and entries get reused
        for (int i = 0; i < 3000; i++) begin
            pa = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
            pb = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
            tg = {$urandom_range(0, 3), 2'b00} << 4;
            pte = $urandom_range(0, 1) ? mpt(pb) : 1'($urandom_range(0, 1));
            cyc($urandom_range(0, 299) == 0, pa, $urandom_range(0, 4) != 0,
                $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), pb, tg, pte,
                $urandom_range(0, 1) ? mnpc(pb) : tg);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
